// File: rtl/slos_detect.sv
// Receive-side SLOS1/SLOS2 detector: acquires polarity and a PRBS11 replica from the
// serial stream, checks every bit while locked and counts clean SLOS periods.
`timescale 1ns/1ps

module slos_detect #(
  parameter logic [10:0] SEED       = 11'h400,
  parameter int          VERIFY_LEN = 32,
  parameter int          ERR_THRESH = 4,
  parameter int          REQ_COUNT  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       data_in,
  output logic       locked,
  output logic       slos_type,
  output logic       slos_rcvd,
  output logic       slos_done,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {
    ST_ACQUIRE = 2'd0,
    ST_VERIFY  = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  localparam logic [7:0] VLEN_LAST = 8'(VERIFY_LEN - 1);
  localparam logic [7:0] ETHRESH   = 8'(ERR_THRESH);
  localparam logic [3:0] RCOUNT    = 4'(REQ_COUNT);

  function automatic logic [10:0] prbs_next(input logic [10:0] cur);
    return {cur[9:0], cur[10] ^ cur[8]};
  endfunction

  // A clean stream satisfies newest == tap9 ^ tap11; any disagreement means inverted data.
  function automatic logic acq_polarity(input logic newest, input logic tap9, input logic tap11);
    return newest ^ tap9 ^ tap11;
  endfunction

  state_t      state_r;
  logic [10:0] shift_r;
  logic [3:0]  bcnt_r;
  logic [10:0] repl_r;
  logic        held_r;
  logic        pol_r;
  logic [7:0]  vcnt_r;
  logic [7:0]  perr_r;
  logic [3:0]  good_r;
  logic        first_r;
  logic        locked_r;
  logic        rcvd_r;
  logic        done_r;
  logic [7:0]  err_r;

  logic [11:0] shift_step_s;
  logic        acq_pol_s;
  logic [10:0] repl_step_s;
  logic        held_step_s;
  logic        miss_s;
  logic [3:0]  good_inc_s;
  logic [7:0]  err_inc_s;

  state_t      state_nx_s;
  logic [10:0] shift_nx_s;
  logic [3:0]  bcnt_nx_s;
  logic [10:0] repl_nx_s;
  logic        held_nx_s;
  logic        pol_nx_s;
  logic [7:0]  vcnt_nx_s;
  logic [7:0]  perr_nx_s;
  logic [3:0]  good_nx_s;
  logic        first_nx_s;
  logic        rcvd_nx_s;
  logic        done_nx_s;
  logic [7:0]  err_nx_s;

  assign shift_step_s = {shift_r, data_in};
  assign acq_pol_s    = acq_polarity(shift_step_s[0], shift_step_s[9], shift_step_s[11]);
  assign miss_s       = data_in ^ repl_step_s[0] ^ pol_r;
  assign good_inc_s   = (good_r == RCOUNT) ? good_r : good_r + 4'd1;
  assign err_inc_s    = (err_r == 8'hFF) ? err_r : err_r + 8'd1;

  // Replica advance: the seed state is repeated once per period to mark the boundary.
  always_comb begin
    if (repl_r == SEED && !held_r) begin
      repl_step_s = SEED;
      held_step_s = 1'b1;
    end else begin
      repl_step_s = prbs_next(repl_r);
      held_step_s = 1'b0;
    end
  end

  // Next-state and counter update for acquisition, verification and tracking.
  always_comb begin
    state_nx_s = state_r;
    shift_nx_s = shift_r;
    bcnt_nx_s  = bcnt_r;
    repl_nx_s  = repl_r;
    held_nx_s  = held_r;
    pol_nx_s   = pol_r;
    vcnt_nx_s  = vcnt_r;
    perr_nx_s  = perr_r;
    good_nx_s  = good_r;
    first_nx_s = first_r;
    rcvd_nx_s  = 1'b0;
    done_nx_s  = done_r;
    err_nx_s   = err_r;
    case (state_r)
      ST_ACQUIRE: begin
        shift_nx_s = shift_step_s[10:0];
        if (bcnt_r == 4'd11) begin
          state_nx_s = ST_VERIFY;
          bcnt_nx_s  = 4'd0;
          pol_nx_s   = acq_pol_s;
          repl_nx_s  = shift_step_s[10:0] ^ {11{acq_pol_s}};
          held_nx_s  = 1'b0;
          vcnt_nx_s  = 8'd0;
        end else begin
          bcnt_nx_s = bcnt_r + 4'd1;
        end
      end
      ST_VERIFY: begin
        repl_nx_s = repl_step_s;
        held_nx_s = held_step_s;
        if (miss_s) begin
          state_nx_s = ST_ACQUIRE;
          shift_nx_s = 11'd0;
          bcnt_nx_s  = 4'd0;
          vcnt_nx_s  = 8'd0;
        end else if (vcnt_r == VLEN_LAST) begin
          state_nx_s = ST_LOCKED;
          vcnt_nx_s  = 8'd0;
          perr_nx_s  = 8'd0;
          good_nx_s  = 4'd0;
          first_nx_s = 1'b1;
        end else begin
          vcnt_nx_s = vcnt_r + 8'd1;
        end
      end
      ST_LOCKED: begin
        repl_nx_s = repl_step_s;
        held_nx_s = held_step_s;
        if (miss_s) begin
          err_nx_s = err_inc_s;
        end else begin
          err_nx_s = err_r;
        end
        if (miss_s && (perr_r + 8'd1 == ETHRESH)) begin
          state_nx_s = ST_ACQUIRE;
          shift_nx_s = 11'd0;
          bcnt_nx_s  = 4'd0;
          perr_nx_s  = 8'd0;
          good_nx_s  = 4'd0;
          first_nx_s = 1'b0;
        end else if (held_step_s) begin
          // A mismatch on the boundary bit belongs to the period being closed.
          rcvd_nx_s = 1'b1;
          perr_nx_s = 8'd0;
          if (first_r) begin
            first_nx_s = 1'b0;
            good_nx_s  = 4'd0;
          end else if (!miss_s && perr_r == 8'd0) begin
            good_nx_s = good_inc_s;
            if (good_inc_s == RCOUNT) begin
              done_nx_s = 1'b1;
            end else begin
              done_nx_s = done_r;
            end
          end else begin
            good_nx_s = 4'd0;
          end
        end else begin
          perr_nx_s = perr_r + {7'd0, miss_s};
        end
      end
      default: begin
        state_nx_s = ST_ACQUIRE;
        shift_nx_s = 11'd0;
        bcnt_nx_s  = 4'd0;
      end
    endcase
  end

  // State register; enable low clears everything on the next edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_ACQUIRE;
      shift_r  <= 11'd0;
      bcnt_r   <= 4'd0;
      repl_r   <= 11'd0;
      held_r   <= 1'b0;
      pol_r    <= 1'b0;
      vcnt_r   <= 8'd0;
      perr_r   <= 8'd0;
      good_r   <= 4'd0;
      first_r  <= 1'b0;
      locked_r <= 1'b0;
      rcvd_r   <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 8'd0;
    end else if (!enable) begin
      state_r  <= ST_ACQUIRE;
      shift_r  <= 11'd0;
      bcnt_r   <= 4'd0;
      repl_r   <= 11'd0;
      held_r   <= 1'b0;
      pol_r    <= 1'b0;
      vcnt_r   <= 8'd0;
      perr_r   <= 8'd0;
      good_r   <= 4'd0;
      first_r  <= 1'b0;
      locked_r <= 1'b0;
      rcvd_r   <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 8'd0;
    end else begin
      state_r  <= state_nx_s;
      shift_r  <= shift_nx_s;
      bcnt_r   <= bcnt_nx_s;
      repl_r   <= repl_nx_s;
      held_r   <= held_nx_s;
      pol_r    <= pol_nx_s;
      vcnt_r   <= vcnt_nx_s;
      perr_r   <= perr_nx_s;
      good_r   <= good_nx_s;
      first_r  <= first_nx_s;
      locked_r <= (state_nx_s == ST_LOCKED);
      rcvd_r   <= rcvd_nx_s;
      done_r   <= done_nx_s;
      err_r    <= err_nx_s;
    end
  end

  assign locked    = locked_r;
  assign slos_type = pol_r;
  assign slos_rcvd = rcvd_r;
  assign slos_done = done_r;
  assign err_cnt   = err_r;

endmodule

// File: tb/tb_slos_detect.sv
// Directed bench for slos_detect: a behavioural SLOS transmitter feeds the detector
// and event cycles (lock, boundaries, done, errors) are compared with hand-derived values.
`timescale 1ns/1ps

module tb_slos_detect;

  localparam logic [10:0] SEED = 11'h400;

  typedef struct {
    logic pol;
    int   offset;
    int   exp_lock;
    int   exp_rcvd1;
    int   exp_done;
  } scen_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       data_in;
  logic       locked;
  logic       slos_type;
  logic       slos_rcvd;
  logic       slos_done;
  logic [7:0] err_cnt;

  slos_detect dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .data_in   (data_in),
    .locked    (locked),
    .slos_type (slos_type),
    .slos_rcvd (slos_rcvd),
    .slos_done (slos_done),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc;
  int rise_cyc, fall_cyc, rcvd1_cyc, rcvd_cnt, done_cyc;
  logic type_at_lock;
  logic prev_locked;

  logic [10:0] tx_reg;
  logic        tx_held;
  logic        tx_pol;

  scen_t tbl [3];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tx_adv();
    if (tx_reg == SEED && !tx_held) begin
      tx_held = 1'b1;
    end else begin
      tx_reg  = {tx_reg[9:0], tx_reg[10] ^ tx_reg[8]};
      tx_held = 1'b0;
    end
  endtask

  task automatic clear_mon();
    rise_cyc    = -1;
    fall_cyc    = -1;
    rcvd1_cyc   = -1;
    rcvd_cnt    = 0;
    done_cyc    = -1;
    type_at_lock = 1'b0;
    prev_locked = locked;
  endtask

  // One bit period; cycle k's outputs are observed as "cycle k+1".
  task automatic step(input logic flip);
    @(negedge clk);
    enable  = 1'b1;
    data_in = tx_reg[0] ^ tx_pol ^ flip;
    @(posedge clk);
    #1;
    tx_adv();
    cyc++;
    if (locked && !prev_locked) begin
      rise_cyc     = cyc;
      type_at_lock = slos_type;
    end
    if (!locked && prev_locked) fall_cyc = cyc;
    prev_locked = locked;
    if (slos_rcvd) begin
      rcvd_cnt++;
      if (rcvd1_cyc < 0) rcvd1_cyc = cyc;
    end
    if (slos_done && done_cyc < 0) done_cyc = cyc;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step(1'b0);
  endtask

  task automatic restart(input string name, input logic pol, input int offset);
    @(negedge clk);
    enable  = 1'b0;
    data_in = 1'b0;
    @(posedge clk);
    #1;
    chk(name, int'({locked, slos_type, slos_rcvd, slos_done, err_cnt}), 0);
    tx_reg  = SEED;
    tx_held = 1'b0;
    tx_pol  = pol;
    for (int i = 0; i < offset; i++) tx_adv();
    cyc = 0;
    clear_mon();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    tbl[0] = '{pol: 1'b0, offset: 0,    exp_lock: 44, exp_rcvd1: 2050, exp_done: 6146};
    tbl[1] = '{pol: 1'b1, offset: 0,    exp_lock: 44, exp_rcvd1: 2050, exp_done: 6146};
    tbl[2] = '{pol: 1'b0, offset: 2038, exp_lock: 58, exp_rcvd1: 2060, exp_done: 6156};

    cyc     = 0;
    reset   = 1'b0;
    enable  = 1'b0;
    data_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", int'({locked, slos_type, slos_rcvd, slos_done, err_cnt}), 0);
    @(negedge clk);
    reset = 1'b1;

    // Clean SLOS1, SLOS2 and hold-in-acquisition-window streams.
    for (int t = 0; t < 3; t++) begin
      restart("idle_before_scenario", tbl[t].pol, tbl[t].offset);
      run_to(6200);
      chk("lock_cycle",  rise_cyc,  tbl[t].exp_lock);
      chk("slos_type",   int'(type_at_lock), int'(tbl[t].pol));
      chk("first_rcvd",  rcvd1_cyc, tbl[t].exp_rcvd1);
      chk("rcvd_count",  rcvd_cnt,  3);
      chk("done_cycle",  done_cyc,  tbl[t].exp_done);
      chk("err_clean",   int'(err_cnt), 0);
      chk("still_locked", int'(locked), 1);
    end

    // Single flipped bit in the second period delays done by one period.
    restart("idle_t4", 1'b0, 0);
    run_to(3000);
    step(1'b1);
    chk("t4_err_one",   int'(err_cnt), 1);
    chk("t4_locked",    int'(locked), 1);
    run_to(8250);
    chk("t4_done_cycle", done_cyc, 8194);
    chk("t4_rcvd_count", rcvd_cnt, 4);
    for (int i = 0; i < 4; i++) step(1'b1);
    chk("t4_drop_cycle", fall_cyc, 8254);
    chk("t4_done_sticky", int'(slos_done), 1);
    chk("t4_err_five",   int'(err_cnt), 5);
    run_to(8310);
    chk("t4_relock",     rise_cyc, 8298);

    // Four flips in one period drop lock, then a clean relock.
    restart("idle_t5", 1'b0, 0);
    run_to(100);
    for (int i = 0; i < 4; i++) step(1'b1);
    chk("t5_drop_cycle", fall_cyc, 104);
    chk("t5_err_four",   int'(err_cnt), 4);
    run_to(160);
    chk("t5_relock",     rise_cyc, 148);
    chk("t5_type",       int'(slos_type), 0);
    chk("t5_err_kept",   int'(err_cnt), 4);

    // SLOS1 -> SLOS2 switch, then repeated switches to saturate err_cnt.
    restart("idle_t6", 1'b0, 0);
    run_to(200);
    tx_pol = 1'b1;
    run_to(260);
    chk("t6_drop_cycle", fall_cyc, 204);
    chk("t6_relock",     rise_cyc, 248);
    chk("t6_type",       int'(slos_type), 1);
    chk("t6_err_four",   int'(err_cnt), 4);
    for (int r = 0; r < 63; r++) begin
      tx_pol = ~tx_pol;
      k = 0;
      while (locked && k < 20) begin
        step(1'b0);
        k++;
      end
      chk("sat_drop", int'(locked), 0);
      k = 0;
      while (!locked && k < 400) begin
        step(1'b0);
        k++;
      end
      chk("sat_relock", int'(locked), 1);
    end
    chk("err_saturated", int'(err_cnt), 255);
    chk("sat_type",      int'(slos_type), int'(tx_pol));

    restart("enable_low_clears", 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
